// File: rtl/bmd_latency_stamp_fifo.sv
// Purpose: stamps the wait counter on per-channel SOP pulses, queues {ch_id, ts} in a FIFO, raises a drain request.
// Latency: SOP to FIFO entry 3 cycles uncontended (+1 per lower-index contender); rd_en to rd_data/rd_valid 1 cycle.
// Backpressure: when the FIFO is full, holding registers keep their stamps; a SOP on an occupied channel is dropped and counted.
//
// Ports:
//   clk, rst (async, active-high), latency_reset_signal (sync clear of everything)
//   ch_sop[NUM_CH], waiting_counter[TS_WIDTH] : capture inputs, registered once before use
//   rd_en -> rd_data {ch_id, ts} / rd_valid   : registered read port
//   fifo_count, fifo_full, fifo_empty         : occupancy status
//   drop_count (saturating), read_trigger     : stamp loss counter and drain request

module bmd_latency_stamp_fifo #(
    parameter int TS_WIDTH     = 30,
    parameter int DEPTH_LOG2   = 13,
    parameter int NUM_CH       = 2,
    parameter int CH_ID_W      = 3,
    parameter int DRAIN_MODE   = 0,
    parameter int DRAIN_THRESH = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        latency_reset_signal,
    input  logic [NUM_CH-1:0]           ch_sop,
    input  logic [TS_WIDTH-1:0]         waiting_counter,
    input  logic                        rd_en,
    output logic [CH_ID_W+TS_WIDTH-1:0] rd_data,
    output logic                        rd_valid,
    output logic [DEPTH_LOG2:0]         fifo_count,
    output logic                        fifo_full,
    output logic                        fifo_empty,
    output logic [15:0]                 drop_count,
    output logic                        read_trigger
);

    localparam int                    DEPTH      = 1 << DEPTH_LOG2;
    localparam int                    EW         = CH_ID_W + TS_WIDTH;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   THRESH_CNT = (DEPTH_LOG2+1)'(DRAIN_THRESH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                  state, state_next;
    logic [NUM_CH-1:0]       sop_q;
    logic [TS_WIDTH-1:0]     cnt_q;
    logic [NUM_CH-1:0]       hold_vld;
    logic [TS_WIDTH-1:0]     hold_ts [NUM_CH];
    logic [EW-1:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;

    logic                    wr, rd, any_hold, drain_cond;
    logic [CH_ID_W-1:0]      win_idx;
    logic [TS_WIDTH-1:0]     win_ts;
    logic [NUM_CH-1:0]       clr, drop_vec;
    logic [3:0]              drop_num;
    logic [16:0]             drop_sum;
    logic [15:0]             drop_next;
    logic [DEPTH_LOG2:0]     count_next;

    // Input buffer: both capture inputs see exactly one register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sop_q <= '0;
            cnt_q <= '0;
        end else if (latency_reset_signal) begin
            sop_q <= '0;
            cnt_q <= '0;
        end else begin
            sop_q <= ch_sop;
            cnt_q <= waiting_counter;
        end
    end

    // Arbitration: descending scan so the lowest valid index is the last (winning) assignment.
    // A channel whose stamp is being written this cycle counts as free for a new SOP.
    always_comb begin
        any_hold = 1'b0;
        win_idx  = '0;
        win_ts   = '0;
        for (int c = NUM_CH-1; c >= 0; c--) begin
            if (hold_vld[c]) begin
                any_hold = 1'b1;
                win_idx  = CH_ID_W'(c);
                win_ts   = hold_ts[c];
            end
        end
        wr       = any_hold & ~fifo_full;
        rd       = rd_en & ~fifo_empty;
        clr      = '0;
        drop_vec = '0;
        drop_num = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            clr[c]      = wr && (win_idx == CH_ID_W'(c));
            drop_vec[c] = sop_q[c] & hold_vld[c] & ~clr[c];
            drop_num    = drop_num + {3'b000, drop_vec[c]};
        end
        drop_sum  = {1'b0, drop_count} + {13'b0, drop_num};
        drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_comb begin
        count_next = fifo_count;
        if (wr && !rd) begin
            count_next = fifo_count + CNT_ONE;
        end else if (rd && !wr) begin
            count_next = fifo_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_vld <= '0;
            for (int c = 0; c < NUM_CH; c++) hold_ts[c] <= '0;
        end else if (latency_reset_signal) begin
            hold_vld <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clr[c]) hold_vld[c] <= 1'b0;
                if (sop_q[c] && !drop_vec[c]) begin
                    hold_vld[c] <= 1'b1;
                    hold_ts[c]  <= cnt_q;
                end
            end
        end
    end

    // Storage array carries no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (wr && !latency_reset_signal) mem[wr_ptr] <= {win_idx, win_ts};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            drop_count <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else if (latency_reset_signal) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            drop_count <= '0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                rd_data <= mem[rd_ptr];
            end
            rd_valid   <= rd;
            fifo_count <= count_next;
            fifo_full  <= (count_next == DEPTH_CNT);
            fifo_empty <= (count_next == '0);
            drop_count <= drop_next;
        end
    end

    // Drain FSM: stays in DRAIN until both the FIFO and every holding register are empty.
    assign drain_cond = (DRAIN_MODE == 0) ? fifo_full : (fifo_count >= THRESH_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else if (latency_reset_signal) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (drain_cond) state_next = DRAIN;
            DRAIN:   if (fifo_empty && !(|hold_vld)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign read_trigger = (state == DRAIN);

endmodule

// File: tb/tb_bmd_latency_stamp_fifo.sv
module tb_bmd_latency_stamp_fifo;

    localparam int EW    = 18;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lrs = 1'b0;
    logic [2:0]  ch_sop = 3'b000;
    logic [15:0] wc = 16'd0;
    logic        rd_en = 1'b0;

    logic [EW-1:0] rdd  [2];
    logic          rdv  [2];
    logic [4:0]    cnt  [2];
    logic          full [2];
    logic          empty[2];
    logic [15:0]   drop [2];
    logic          trig [2];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bmd_latency_stamp_fifo #(.TS_WIDTH(16), .DEPTH_LOG2(4), .NUM_CH(3), .CH_ID_W(2),
                             .DRAIN_MODE(0), .DRAIN_THRESH(16)) dut0 (
        .clk(clk), .rst(rst), .latency_reset_signal(lrs), .ch_sop(ch_sop),
        .waiting_counter(wc), .rd_en(rd_en), .rd_data(rdd[0]), .rd_valid(rdv[0]),
        .fifo_count(cnt[0]), .fifo_full(full[0]), .fifo_empty(empty[0]),
        .drop_count(drop[0]), .read_trigger(trig[0]));

    bmd_latency_stamp_fifo #(.TS_WIDTH(16), .DEPTH_LOG2(4), .NUM_CH(3), .CH_ID_W(2),
                             .DRAIN_MODE(1), .DRAIN_THRESH(5)) dut1 (
        .clk(clk), .rst(rst), .latency_reset_signal(lrs), .ch_sop(ch_sop),
        .waiting_counter(wc), .rd_en(rd_en), .rd_data(rdd[1]), .rd_valid(rdv[1]),
        .fifo_count(cnt[1]), .fifo_full(full[1]), .fifo_empty(empty[1]),
        .drop_count(drop[1]), .read_trigger(trig[1]));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of {ch, ts} entries, one stamp slot per channel,
    // a one-cycle-delayed copy of the capture inputs, and a drain flag per instance.
    logic [EW-1:0] mq[$];
    bit            hv [3] = '{0, 0, 0};
    logic [15:0]   hts[3] = '{16'd0, 16'd0, 16'd0};
    logic [2:0]    m_sop_q = 3'b000;
    logic [15:0]   m_ts_q = 16'd0;
    logic [EW-1:0] m_rdd = '0;
    bit            m_rdv = 0;
    int            m_drop = 0;
    bit            m_st[2] = '{0, 0};

    always @(posedge clk or posedge rst) begin
        int  pre_n;
        bit  any_h;
        bit  cond;
        int  win;
        if (rst || lrs) begin
            mq.delete();
            for (int c = 0; c < 3; c++) hv[c] = 0;
            m_sop_q = 3'b000;
            m_rdd   = '0;
            m_rdv   = 0;
            m_drop  = 0;
            m_st[0] = 0;
            m_st[1] = 0;
        end else begin
            pre_n = mq.size();
            any_h = hv[0] || hv[1] || hv[2];
            for (int i = 0; i < 2; i++) begin
                cond = (i == 0) ? (pre_n == DEPTH) : (pre_n >= 5);
                if (!m_st[i]) m_st[i] = cond;
                else if (pre_n == 0 && !any_h) m_st[i] = 0;
            end
            m_rdv = 0;
            if (rd_en && pre_n > 0) begin
                m_rdd = mq.pop_front();
                m_rdv = 1;
            end
            win = -1;
            if (pre_n < DEPTH) begin
                for (int c = 0; c < 3; c++) if (hv[c] && win < 0) win = c;
            end
            if (win >= 0) begin
                mq.push_back({2'(win), hts[win]});
                hv[win] = 0;
            end
            for (int c = 0; c < 3; c++) begin
                if (m_sop_q[c]) begin
                    if (hv[c]) begin
                        if (m_drop < 65535) m_drop++;
                    end else begin
                        hv[c]  = 1;
                        hts[c] = m_ts_q;
                    end
                end
            end
            m_sop_q = ch_sop;
            m_ts_q  = wc;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dut%0d.fifo_count", i), 64'(cnt[i]), 64'(mq.size()));
            chk($sformatf("dut%0d.fifo_full", i), 64'(full[i]), 64'(mq.size() == DEPTH));
            chk($sformatf("dut%0d.fifo_empty", i), 64'(empty[i]), 64'(mq.size() == 0));
            chk($sformatf("dut%0d.drop_count", i), 64'(drop[i]), 64'(m_drop));
            chk($sformatf("dut%0d.read_trigger", i), 64'(trig[i]), 64'(m_st[i]));
            chk($sformatf("dut%0d.rd_valid", i), 64'(rdv[i]), 64'(m_rdv));
            chk($sformatf("dut%0d.rd_data", i), 64'(rdd[i]), 64'(m_rdd));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [EW-1:0] exp_e;
        int            rdp;

        repeat (3) @(negedge clk);
        chk("reset.count", 64'(cnt[0]), 64'd0);
        chk("reset.empty", 64'(empty[0]), 64'd1);
        chk("reset.trigger", 64'(trig[1]), 64'd0);
        rst = 1'b0;

        // Two channels stamped in the same cycle: ch0 first, ch1 next cycle.
        @(negedge clk); ch_sop = 3'b011; wc = 16'd50;
        @(negedge clk); ch_sop = 3'b000;
        @(negedge clk); chk("cont.count_t2", 64'(cnt[0]), 64'd0);
        @(negedge clk); chk("cont.count_t3", 64'(cnt[0]), 64'd1);
        @(negedge clk); chk("cont.count_t4", 64'(cnt[0]), 64'd2);
        chk("cont.drop", 64'(drop[0]), 64'd0);
        rd_en = 1'b1;
        @(negedge clk); chk("cont.rd0", 64'({rdv[0], rdd[0]}), 64'({1'b1, 2'd0, 16'd50}));
        @(negedge clk); rd_en = 1'b0;
        chk("cont.rd1", 64'({rdv[0], rdd[0]}), 64'({1'b1, 2'd1, 16'd50}));
        @(negedge clk); chk("cont.empty", 64'(empty[0]), 64'd1);
        rd_en = 1'b1;
        @(negedge clk); rd_en = 1'b0;
        chk("rd_empty.valid", 64'(rdv[0]), 64'd0);
        chk("rd_empty.hold", 64'(rdd[0]), 64'({2'd1, 16'd50}));

        // Fill to full, threshold trigger, drops while full, write+read at full.
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 6)  chk("fill.count4", 64'(cnt[0]), 64'd4);
            if (k == 7)  chk("thr.no_trig_at4", 64'(trig[1]), 64'd0);
            if (k == 7)  chk("fill.count5", 64'(cnt[1]), 64'd5);
            if (k == 8)  chk("thr.trig", 64'(trig[1]), 64'd1);
            if (k == 18) chk("fill.full", 64'(full[0]), 64'd1);
            if (k == 18) chk("fill.trig_not_yet", 64'(trig[0]), 64'd0);
            if (k == 19) chk("fill.trig", 64'(trig[0]), 64'd1);
            if (k == 23) chk("drop.one", 64'(drop[0]), 64'd1);
            if (k == 24) chk("drop.two", 64'(drop[0]), 64'd2);
            if (k == 24) chk("drop.count_full", 64'(cnt[0]), 64'd16);
            if (k == 25) chk("drop.count_pop", 64'(cnt[0]), 64'd15);
            if (k == 25) chk("drop.rd", 64'(rdd[0]), 64'({2'd0, 16'd100}));
            if (k == 26) chk("drop.held_written", 64'(cnt[0]), 64'd16);
            if (k == 27) chk("wrrd.count_pop", 64'(cnt[0]), 64'd15);
            if (k == 27) chk("wrrd.rd", 64'(rdd[0]), 64'({2'd0, 16'd101}));
            if (k == 29) chk("wrrd.refull", 64'(cnt[0]), 64'd16);
            ch_sop = 3'b000;
            if (k < 16) begin
                ch_sop = 3'b001; wc = 16'(100 + k);
            end else if (k >= 20 && k <= 22) begin
                ch_sop = 3'b001; wc = 16'(200 + k - 20);
            end else if (k == 26) begin
                ch_sop = 3'b010; wc = 16'd300;
            end
            rd_en = (k == 24 || k == 26);
        end

        // Drain everything: 102..115, the held 200, then ch1's 300.
        @(negedge clk); rd_en = 1'b1;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            if (j == 15) rd_en = 1'b0;
            if (j < 14)       exp_e = {2'd0, 16'(102 + j)};
            else if (j == 14) exp_e = {2'd0, 16'd200};
            else              exp_e = {2'd1, 16'd300};
            chk($sformatf("drain.rd%0d", j), 64'({rdv[0], rdd[0]}), 64'({1'b1, exp_e}));
        end
        @(negedge clk);
        chk("drain.empty", 64'(empty[0]), 64'd1);
        chk("drain.trig0_off", 64'(trig[0]), 64'd0);
        chk("drain.trig1_off", 64'(trig[1]), 64'd0);

        // Seven entries on ch2, then a synchronous clear while dut1 drains.
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 9)  chk("lrs.count7", 64'(cnt[0]), 64'd7);
            if (k == 10) chk("lrs.trig1_on", 64'(trig[1]), 64'd1);
            if (k == 10) chk("lrs.trig0_off", 64'(trig[0]), 64'd0);
            if (k == 11) begin
                chk("lrs.count", 64'(cnt[1]), 64'd0);
                chk("lrs.empty", 64'(empty[1]), 64'd1);
                chk("lrs.trig", 64'(trig[1]), 64'd0);
                chk("lrs.drop", 64'(drop[1]), 64'd0);
            end
            ch_sop = (k < 7) ? 3'b100 : 3'b000;
            wc     = 16'(400 + k);
            lrs    = (k == 10);
        end

        // Randomized traffic with varying read pressure.
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0:       rdp = 80;
                1:       rdp = 30;
                2:       rdp = 5;
                default: rdp = 60;
            endcase
            for (int n = 0; n < 600; n++) begin
                @(negedge clk);
                ch_sop = 3'($urandom) & 3'($urandom);
                rd_en  = ($urandom_range(0, 99) < rdp);
                wc     = wc + 16'($urandom_range(1, 3));
            end
        end

        // Fill hard, then an asynchronous reset between clock edges.
        rd_en = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            ch_sop = 3'b111;
            wc     = wc + 16'd1;
        end
        @(negedge clk);
        chk("arst.pre_full", 64'(full[0]), 64'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.count", 64'(cnt[0]), 64'd0);
        chk("arst.empty", 64'(empty[0]), 64'd1);
        chk("arst.full", 64'(full[0]), 64'd0);
        chk("arst.drop", 64'(drop[0]), 64'd0);
        chk("arst.trig", 64'(trig[0]), 64'd0);
        chk("arst.rd_data", 64'(rdd[0]), 64'd0);
        @(negedge clk);
        ch_sop = 3'b000;
        rst    = 1'b0;
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bmd_latency_stamp_fifo.md
Name: bmd_latency_stamp_fifo

Overview:
Multi-channel successor to the single-channel CQ-SOP timestamp FIFO. It captures the free-running wait counter on each channel's start-of-packet pulse. It stores the value tagged with its channel ID in an internal synchronous FIFO, so no vendor IP is used. A drain trigger tells the TX side when to read the results out. The block sits between the RX request path (SOP pulses and counter) and the TX result-packet builder.

Parameters:
TS_WIDTH, 30, timestamp width in bits
DEPTH_LOG2, 13, log2 of FIFO depth (8192 entries)
NUM_CH, 2, number of SOP input channels (1..8)
CH_ID_W, 3, channel-ID field width; must satisfy 2^CH_ID_W >= NUM_CH
DRAIN_MODE, 0, 0 = trigger on full; 1 = trigger when count >= DRAIN_THRESH
DRAIN_THRESH, 4096, fill level for DRAIN_MODE=1 (1..2^DEPTH_LOG2)

Ports:
clk  in  1  single clock, 250 MHz
rst  in  1  asynchronous, active-high reset
latency_reset_signal  in  1  synchronous clear of FIFO, holding regs, counters and FSM
ch_sop  in  NUM_CH  per-channel SOP pulse, one bit per channel
waiting_counter  in  TS_WIDTH  free-running counter to be stamped
rd_en  in  1  read request from TX
rd_data  out  CH_ID_W+TS_WIDTH  {ch_id, timestamp}, registered
rd_valid  out  1  rd_data valid; single-cycle pulse
fifo_count  out  DEPTH_LOG2+1  current occupancy
fifo_full  out  1  occupancy == 2^DEPTH_LOG2
fifo_empty  out  1  occupancy == 0
drop_count  out  16  saturating count of lost stamps
read_trigger  out  1  drain request to TX

Behaviour:
- Reset (rst=1, async): every output is 0 except fifo_empty=1. Pointers, holding regs, drop_count and the FSM are cleared to IDLE.
- latency_reset_signal=1: same clear as reset, applied synchronously. It has priority over every other event in that cycle.
- Capture stage:
  - ch_sop and waiting_counter are registered one cycle before use (input buffer).
  - Each channel has a 1-entry holding register {valid, ts}.
  - A registered SOP on channel c loads hold[c].ts with the registered counter and sets hold[c].valid.
  - If hold[c].valid is already set and is not being written out this cycle, the new stamp is discarded and drop_count increments.
- Arbitration: at most one FIFO write per cycle. The lowest-index valid holding register wins when the FIFO is not full. The winner's valid bit clears in the same cycle, so a SOP to that channel in that cycle is accepted.
- FIFO full: no write occurs and holding registers keep their data. A SOP arriving on an already-occupied channel counts as a drop.
- drop_count: adds the number of channels dropping in a cycle (it can be more than 1). It saturates at 16'hFFFF.
- Read:
  - rd_en with fifo_empty=0 pops one entry; rd_data and rd_valid appear on the next cycle.
  - rd_en while empty is ignored: no pop, rd_valid=0, rd_data holds its old value.
- Simultaneous write and read: allowed in any state, including full (the pop frees a slot for the next cycle only) and empty (no pop, the write lands). fifo_count is unchanged on a write+read cycle.
- Pointers: DEPTH_LOG2-bit binary pointers that wrap modulo the depth. fifo_count is DEPTH_LOG2+1 bits, so full is distinguishable from empty. fifo_full and fifo_empty are registered from the next-state count.
- Trigger FSM:
  - IDLE: read_trigger=0. Go to DRAIN when the condition holds: fifo_full (DRAIN_MODE=0) or fifo_count >= DRAIN_THRESH (DRAIN_MODE=1).
  - DRAIN: read_trigger=1. Go to IDLE when fifo_empty=1 and no holding register is valid. New writes during DRAIN do not leave the state.
  - read_trigger is registered, so it asserts 1 cycle after the condition is met.
- Latency: SOP to entry visible in fifo_count is 3 cycles (input register, holding register, write) when uncontended. Each extra lower-index contender adds 1 cycle.

Test Plan:
- Single channel: NUM_CH=1, DEPTH_LOG2=4, DRAIN_MODE=0. 16 SOPs with waiting_counter=100..115 → fifo_full=1 and read_trigger=1 one cycle later. 16 reads return ts 100..115 with ch_id 0, in order. After the last pop, fifo_empty=1 and read_trigger=0.
- Contention: NUM_CH=2, SOP on ch0 and ch1 in the same cycle with counter=50 → FIFO receives {0,50} and then {1,50} on consecutive cycles. drop_count=0.
- Drop: SOPs on ch0 on 3 consecutive cycles while the FIFO is full → first stamp held, the next two dropped (drop_count=2). After one read, the held stamp is written.
- Threshold mode: DRAIN_MODE=1, DRAIN_THRESH=5. Write 5 entries → read_trigger=1 one cycle after fifo_count=5. No trigger occurs at count 4.
- Write+read at full: depth 16, full; rd_en and a SOP in the same cycle → one pop. The held stamp is written the following cycle and fifo_count returns to 16.
- Resets: latency_reset_signal mid-drain with 7 entries → next cycle fifo_count=0, fifo_empty=1, read_trigger=0, drop_count=0. Async rst asserted between clock edges clears outputs immediately.
